branch_feedback_queue: RTL and testbench

In-order queue between fetch-stage branch prediction and branch resolution. It holds per-branch prediction metadata (PHT index/tag bundle, predicted direction, PC, GHR snapshot) and maintains the speculative global history register that feeds the base predictor. On resolution it drives the predictor update interface, detects mispredictions and restores the GHR. It is the feedback end of the predictor query/update protocol.

---
 rtl/branch_feedback_queue.sv | 132 +++++++++++++
 tb/tb_branch_feedback_queue.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_feedback_queue.sv
// In-order branch feedback queue: holds per-branch prediction metadata, owns the speculative GHR, drives predictor updates (BFQ_PC_CHECK_EN adds resolved-PC check).
// Latency: update/mispredict strobes are registered, one cycle after the resolve.
// Backpressure: pred_ready_o drops when DEPTH entries are held; a same-cycle pop does not free a slot.
module branch_feedback_queue #(
   parameter int DEPTH      = 8,
   parameter int GHR_WIDTH  = 16,
   parameter int META_WIDTH = 16,
   parameter int PC_WIDTH   = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    pred_valid_i,
   output logic                    pred_ready_o,
   input  logic [PC_WIDTH-1:0]     pred_pc_i,
   input  logic                    pred_taken_i,
   input  logic [META_WIDTH-1:0]   pred_meta_i,
   input  logic                    res_valid_i,
   input  logic                    res_taken_i,
   input  logic [PC_WIDTH-1:0]     res_pc_i,
   input  logic                    flush_i,
   output logic [GHR_WIDTH-1:0]    ghr_o,
   output logic                    upd_valid_o,
   output logic                    upd_taken_o,
   output logic [META_WIDTH-1:0]   upd_meta_o,
   output logic [PC_WIDTH-1:0]     upd_pc_o,
   output logic                    mispredict_o,
   output logic [$clog2(DEPTH):0]  count_o,
   output logic                    pc_mismatch_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   typedef struct packed {
      logic [PC_WIDTH-1:0]   pc;
      logic                  taken;
      logic [META_WIDTH-1:0] meta;
      logic [GHR_WIDTH-1:0]  snap;
   } entry_t;

   entry_t           mem [DEPTH];
   entry_t           head;
   logic [PTR_W-1:0] head_ptr;
   logic [PTR_W-1:0] tail_ptr;
   logic             push;
   logic             pop;
   logic             dir_miss;
   logic             pc_miss;
   logic             mispred;
   logic             wr_en;

   assign pred_ready_o = (count_o < FULL);
   assign push         = pred_valid_i & pred_ready_o;
   assign pop          = res_valid_i & (count_o != '0);
   assign head         = mem[head_ptr];
   assign dir_miss     = pop & (res_taken_i != head.taken);

`ifdef BFQ_PC_CHECK_EN
   assign pc_miss = pop & (res_pc_i != head.pc);
`else
   logic unused_res_pc;
   assign unused_res_pc = ^res_pc_i;
   assign pc_miss       = 1'b0;
`endif

   // A wrong PC is treated like a wrong direction: everything younger is wrong-path.
   assign mispred = dir_miss | pc_miss;
   assign wr_en   = push & ~flush_i & ~mispred;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[tail_ptr] <= '{pc: pred_pc_i, taken: pred_taken_i, meta: pred_meta_i, snap: ghr_o};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count_o  <= '0;
         ghr_o    <= '0;
      end else if (flush_i) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count_o  <= '0;
         if (count_o != '0) begin
            ghr_o <= head.snap;
         end
      end else if (mispred) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count_o  <= '0;
         ghr_o    <= {head.snap[GHR_WIDTH-2:0], res_taken_i};
      end else begin
         if (pop) begin
            head_ptr <= head_ptr + 1'b1;
         end
         if (push) begin
            tail_ptr <= tail_ptr + 1'b1;
            ghr_o    <= {ghr_o[GHR_WIDTH-2:0], pred_taken_i};
         end
         if (push && !pop) begin
            count_o <= count_o + 1'b1;
         end else if (pop && !push) begin
            count_o <= count_o - 1'b1;
         end
      end
   end

   // Update strobes report every pop, including one that coincides with a flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         upd_valid_o   <= 1'b0;
         upd_taken_o   <= 1'b0;
         upd_meta_o    <= '0;
         upd_pc_o      <= '0;
         mispredict_o  <= 1'b0;
         pc_mismatch_o <= 1'b0;
      end else begin
         upd_valid_o   <= pop;
         mispredict_o  <= mispred;
         pc_mismatch_o <= pc_miss;
         if (pop) begin
            upd_taken_o <= res_taken_i;
            upd_meta_o  <= head.meta;
            upd_pc_o    <= head.pc;
         end
      end
   end

endmodule

// File: tb/tb_branch_feedback_queue.sv
// Directed table-driven bench for branch_feedback_queue, plus hand sequences for full/wrap and flush corners.
module tb_branch_feedback_queue;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pred_valid_i = 1'b0;
   logic        pred_ready_o;
   logic [31:0] pred_pc_i = '0;
   logic        pred_taken_i = 1'b0;
   logic [15:0] pred_meta_i = '0;
   logic        res_valid_i = 1'b0;
   logic        res_taken_i = 1'b0;
   logic [31:0] res_pc_i = '0;
   logic        flush_i = 1'b0;
   logic [15:0] ghr_o;
   logic        upd_valid_o;
   logic        upd_taken_o;
   logic [15:0] upd_meta_o;
   logic [31:0] upd_pc_o;
   logic        mispredict_o;
   logic [3:0]  count_o;
   logic        pc_mismatch_o;

   int checks = 0;
   int errors = 0;

   branch_feedback_queue dut (
      .clk(clk), .rst_n(rst_n),
      .pred_valid_i(pred_valid_i), .pred_ready_o(pred_ready_o),
      .pred_pc_i(pred_pc_i), .pred_taken_i(pred_taken_i), .pred_meta_i(pred_meta_i),
      .res_valid_i(res_valid_i), .res_taken_i(res_taken_i), .res_pc_i(res_pc_i),
      .flush_i(flush_i), .ghr_o(ghr_o),
      .upd_valid_o(upd_valid_o), .upd_taken_o(upd_taken_o),
      .upd_meta_o(upd_meta_o), .upd_pc_o(upd_pc_o),
      .mispredict_o(mispredict_o), .count_o(count_o), .pc_mismatch_o(pc_mismatch_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, pv, pt;
      logic [31:0] pc;
      logic [15:0] meta;
      logic        rv, rt;
      logic [31:0] rpc;
      logic        fl;
      logic [15:0] e_ghr;
      logic [3:0]  e_cnt;
      logic        e_rdy, e_uv, e_ut;
      logic [15:0] e_meta;
      logic [31:0] e_pc;
      logic        e_mis, e_pcm;
   } vec_t;

   localparam int NV = 24;
   vec_t tbl [NV];

   function automatic vec_t mk(int rst, int pv, int pt, int pc, int meta, int rv, int rt, int rpc, int fl,
                               int ghr, int cnt, int rdy, int uv, int ut, int umeta, int upc, int mis, int pcm);
      vec_t v;
      v.rst = rst[0]; v.pv = pv[0]; v.pt = pt[0]; v.pc = pc; v.meta = meta[15:0];
      v.rv = rv[0]; v.rt = rt[0]; v.rpc = rpc; v.fl = fl[0];
      v.e_ghr = ghr[15:0]; v.e_cnt = cnt[3:0]; v.e_rdy = rdy[0]; v.e_uv = uv[0]; v.e_ut = ut[0];
      v.e_meta = umeta[15:0]; v.e_pc = upc; v.e_mis = mis[0]; v.e_pcm = pcm[0];
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      pred_valid_i = 1'b0; pred_taken_i = 1'b0; pred_meta_i = '0; pred_pc_i = '0;
      res_valid_i = 1'b0; res_taken_i = 1'b0; res_pc_i = '0; flush_i = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
   endtask

   logic [15:0] mq[$];
   logic [15:0] exp_meta;
   logic [7:0]  pat;

   initial begin
      //          rst pv pt pc      meta  rv rt rpc     fl  ghr    cnt rdy uv ut meta  upc     mis pcm
      tbl[0]  = mk(0, 0, 0, 0,      0,    0, 0, 0,      0,  'h0,   0,  1,  0, 0, 0,    0,      0, 0);
      tbl[1]  = mk(0, 1, 1, 'h1000, 'h11, 0, 0, 0,      0,  'h1,   1,  1,  0, 0, 0,    0,      0, 0);
      tbl[2]  = mk(0, 1, 0, 'h1004, 'h22, 0, 0, 0,      0,  'h2,   2,  1,  0, 0, 0,    0,      0, 0);
      tbl[3]  = mk(0, 1, 1, 'h1008, 'h33, 0, 0, 0,      0,  'h5,   3,  1,  0, 0, 0,    0,      0, 0);
      tbl[4]  = mk(0, 0, 0, 0,      0,    1, 1, 'h1000, 0,  'h5,   2,  1,  1, 1, 'h11, 'h1000, 0, 0);
      tbl[5]  = mk(0, 0, 0, 0,      0,    1, 0, 'h1004, 0,  'h5,   1,  1,  1, 0, 'h22, 'h1004, 0, 0);
      tbl[6]  = mk(0, 0, 0, 0,      0,    1, 1, 'h1008, 0,  'h5,   0,  1,  1, 1, 'h33, 'h1008, 0, 0);
      tbl[7]  = mk(0, 0, 0, 0,      0,    1, 1, 0,      0,  'h5,   0,  1,  0, 0, 0,    0,      0, 0);
      tbl[8]  = mk(0, 1, 1, 'h1010, 'h99, 0, 0, 0,      0,  'hB,   1,  1,  0, 0, 0,    0,      0, 0);
      tbl[9]  = mk(1, 0, 0, 0,      0,    1, 1, 'h1010, 0,  'h0,   0,  1,  0, 0, 0,    0,      0, 0);
      tbl[10] = mk(0, 1, 1, 'h2000, 'h41, 0, 0, 0,      0,  'h1,   1,  1,  0, 0, 0,    0,      0, 0);
      tbl[11] = mk(0, 1, 1, 'h2004, 'h42, 0, 0, 0,      0,  'h3,   2,  1,  0, 0, 0,    0,      0, 0);
      tbl[12] = mk(0, 1, 1, 'h2008, 'h43, 0, 0, 0,      0,  'h7,   3,  1,  0, 0, 0,    0,      0, 0);
      tbl[13] = mk(0, 1, 1, 'h200C, 'h44, 0, 0, 0,      0,  'hF,   4,  1,  0, 0, 0,    0,      0, 0);
      tbl[14] = mk(0, 1, 1, 'h2010, 'h45, 1, 0, 'h2000, 0,  'h0,   0,  1,  1, 0, 'h41, 'h2000, 1, 0);
      tbl[15] = mk(0, 1, 1, 'h2014, 'h50, 0, 0, 0,      0,  'h1,   1,  1,  0, 0, 0,    0,      0, 0);
      tbl[16] = mk(0, 1, 0, 'h2018, 'h51, 0, 0, 0,      0,  'h2,   2,  1,  0, 0, 0,    0,      0, 0);
      tbl[17] = mk(0, 1, 1, 'h201C, 'h52, 1, 1, 'h2014, 0,  'h5,   2,  1,  1, 1, 'h50, 'h2014, 0, 0);
      tbl[18] = mk(0, 1, 1, 'h2020, 'h53, 0, 0, 0,      1,  'h1,   0,  1,  0, 0, 0,    0,      0, 0);
      tbl[19] = mk(1, 0, 0, 0,      0,    0, 0, 0,      0,  'h0,   0,  1,  0, 0, 0,    0,      0, 0);
      tbl[20] = mk(0, 1, 1, 'h1C04, 'h66, 0, 0, 0,      0,  'h1,   1,  1,  0, 0, 0,    0,      0, 0);
      tbl[21] = mk(0, 1, 1, 'h1C08, 'h77, 0, 0, 0,      0,  'h3,   2,  1,  0, 0, 0,    0,      0, 0);
`ifdef BFQ_PC_CHECK_EN
      tbl[22] = mk(0, 0, 0, 0,      0,    1, 1, 'h1C00, 0,  'h1,   0,  1,  1, 1, 'h66, 'h1C04, 1, 1);
      tbl[23] = mk(0, 0, 0, 0,      0,    1, 1, 'h1C08, 0,  'h1,   0,  1,  0, 0, 0,    0,      0, 0);
`else
      tbl[22] = mk(0, 0, 0, 0,      0,    1, 1, 'h1C00, 0,  'h3,   1,  1,  1, 1, 'h66, 'h1C04, 0, 0);
      tbl[23] = mk(0, 0, 0, 0,      0,    1, 1, 'h1C08, 0,  'h3,   0,  1,  1, 1, 'h77, 'h1C08, 0, 0);
`endif

      do_reset();
      for (int i = 0; i < NV; i++) begin
         rst_n        = ~tbl[i].rst;
         pred_valid_i = tbl[i].pv;  pred_taken_i = tbl[i].pt;
         pred_pc_i    = tbl[i].pc;  pred_meta_i  = tbl[i].meta;
         res_valid_i  = tbl[i].rv;  res_taken_i  = tbl[i].rt;
         res_pc_i     = tbl[i].rpc; flush_i      = tbl[i].fl;
         cycle();
         chk($sformatf("v%0d ghr", i), ghr_o, tbl[i].e_ghr);
         chk($sformatf("v%0d count", i), count_o, tbl[i].e_cnt);
         chk($sformatf("v%0d ready", i), pred_ready_o, tbl[i].e_rdy);
         chk($sformatf("v%0d upd_valid", i), upd_valid_o, tbl[i].e_uv);
         chk($sformatf("v%0d mispredict", i), mispredict_o, tbl[i].e_mis);
         chk($sformatf("v%0d pc_mismatch", i), pc_mismatch_o, tbl[i].e_pcm);
         if (tbl[i].e_uv) begin
            chk($sformatf("v%0d upd_taken", i), upd_taken_o, tbl[i].e_ut);
            chk($sformatf("v%0d upd_meta", i), upd_meta_o, tbl[i].e_meta);
            chk($sformatf("v%0d upd_pc", i), upd_pc_o, tbl[i].e_pc);
         end
      end
      idle_inputs();
      rst_n = 1'b1;

      // Fill to DEPTH, overflow attempts, then streaming push/pop across the wrap.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         pred_valid_i = 1'b1; pred_taken_i = 1'b1; pred_meta_i = 16'h80 + 16'(i);
         cycle();
         mq.push_back(16'h80 + 16'(i));
      end
      idle_inputs();
      cycle();
      chk("full ready", pred_ready_o, 1'b0);
      chk("full count", count_o, 4'd8);
      pred_valid_i = 1'b1; pred_taken_i = 1'b1; pred_meta_i = 16'hFF;
      cycle();
      chk("overflow count", count_o, 4'd8);
      pred_meta_i = 16'hEE; res_valid_i = 1'b1; res_taken_i = 1'b1;
      cycle();
      exp_meta = mq.pop_front();
      chk("full pushpop count", count_o, 4'd7);
      chk("full pushpop upd_valid", upd_valid_o, 1'b1);
      chk("full pushpop meta", upd_meta_o, exp_meta);
      for (int i = 0; i < 20; i++) begin
         pred_valid_i = 1'b1; pred_taken_i = 1'b1; pred_meta_i = 16'h100 + 16'(i);
         res_valid_i = 1'b1; res_taken_i = 1'b1;
         cycle();
         exp_meta = mq.pop_front();
         mq.push_back(16'h100 + 16'(i));
         chk($sformatf("stream%0d meta", i), upd_meta_o, exp_meta);
         chk($sformatf("stream%0d count", i), count_o, 4'd7);
      end
      idle_inputs();
      for (int i = 0; i < 7; i++) begin
         res_valid_i = 1'b1; res_taken_i = 1'b1;
         cycle();
         exp_meta = mq.pop_front();
         chk($sformatf("drain%0d meta", i), upd_meta_o, exp_meta);
         chk($sformatf("drain%0d mispredict", i), mispredict_o, 1'b0);
      end
      idle_inputs();
      cycle();
      chk("drained count", count_o, 4'd0);

      // Build GHR 0x00A0, then flush with two entries whose snapshots are 0x00A0 and 0x0141.
      do_reset();
      pat = 8'b1010_0000;
      for (int i = 0; i < 8; i++) begin
         pred_valid_i = 1'b1; pred_taken_i = pat[7-i]; pred_meta_i = 16'(i);
         cycle();
      end
      idle_inputs();
      for (int i = 0; i < 8; i++) begin
         res_valid_i = 1'b1; res_taken_i = pat[7-i];
         cycle();
      end
      idle_inputs();
      cycle();
      chk("pattern ghr", ghr_o, 16'h00A0);
      chk("pattern count", count_o, 4'd0);
      pred_valid_i = 1'b1; pred_taken_i = 1'b1; pred_meta_i = 16'hA0;
      cycle();
      chk("snap ghr1", ghr_o, 16'h0141);
      pred_taken_i = 1'b0; pred_meta_i = 16'hA1;
      cycle();
      chk("snap ghr2", ghr_o, 16'h0282);
      idle_inputs();
      flush_i = 1'b1;
      cycle();
      chk("flush ghr", ghr_o, 16'h00A0);
      chk("flush count", count_o, 4'd0);
      cycle();
      chk("flush empty ghr", ghr_o, 16'h00A0);
      idle_inputs();
      res_valid_i = 1'b1; res_taken_i = 1'b1;
      cycle();
      chk("resolve empty upd_valid", upd_valid_o, 1'b0);
      chk("resolve empty count", count_o, 4'd0);

      // Flush coinciding with a correct resolve: update still reported, GHR restored by flush.
      idle_inputs();
      pred_valid_i = 1'b1; pred_taken_i = 1'b1; pred_meta_i = 16'hB1;
      cycle();
      pred_meta_i = 16'hB2;
      cycle();
      chk("pre-flush ghr", ghr_o, 16'h0283);
      idle_inputs();
      flush_i = 1'b1; res_valid_i = 1'b1; res_taken_i = 1'b1;
      cycle();
      chk("flush+res upd_valid", upd_valid_o, 1'b1);
      chk("flush+res meta", upd_meta_o, 16'hB1);
      chk("flush+res ghr", ghr_o, 16'h00A0);
      chk("flush+res count", count_o, 4'd0);
      idle_inputs();
      cycle();
      chk("strobe one cycle", upd_valid_o, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
